ftdi_fifo_bridge: RTL and testbench

- Parametrised successor to the FT245-style FIFO controller.
- Drives the FTDI async FIFO pins (oe/rd/wr strobes, bidirectional data split into in/out/enable) and moves full data words.
- Presents valid/ready streams to the fabric: an RX stream toward the SDRAM writer and a TX stream from the SDRAM reader.
- Adds configurable strobe widths, a registered data path with backpressure, and burst-limited fair arbitration between RX and TX.

---
 rtl/ftdi_pkg.sv | 28 ++
 rtl/ftdi_sync.sv | 27 ++
 rtl/ftdi_fifo_bridge.sv | 155 +++++++++++++++
 tb/tb_ftdi_fifo_bridge.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// Shared types and helpers for the FTDI FIFO bridge: state encoding, pin levels,
// transfer direction and counter sizing.
package ftdi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_STROBE,
        RD_RECOVER,
        WR_SETUP,
        WR_STROBE,
        WR_RECOVER
    } state_t;

    typedef enum logic {
        DIR_RX = 1'b0,
        DIR_TX = 1'b1
    } dir_t;

    // FTDI control pins are active-low.
    localparam logic OFF = 1'b1;
    localparam logic ON  = 1'b0;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ftdi_sync.sv
// Two-flop synchronizer resetting to 1 (inactive level of the FTDI flags).
// Only elaborated when FTDI_SYNC_EN is defined, since nothing else uses it.
`ifdef FTDI_SYNC_EN
module ftdi_sync (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_reg <= 1'b1;
            q_reg    <= 1'b1;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule
`endif

// File: rtl/ftdi_fifo_bridge.sv
// FT245-style async FIFO bridge with valid/ready RX/TX streams and burst-limited arbitration.
// Define FTDI_SYNC_EN to pass rxf/txe through 2-flop synchronizers before arbitration.
module ftdi_fifo_bridge
    import ftdi_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int RD_STROBE_CYC = 2,
    parameter int WR_STROBE_CYC = 2,
    parameter int BURST_MAX     = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rxf,
    input  logic              txe,
    output logic              oe,
    output logic              rd,
    output logic              wr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    output logic              d_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy
);

    localparam int STB_MAX = (RD_STROBE_CYC > WR_STROBE_CYC) ? RD_STROBE_CYC : WR_STROBE_CYC;
    localparam int STB_W   = cnt_w(STB_MAX);
    localparam int BC_W    = cnt_w((BURST_MAX == 0) ? 1 : BURST_MAX);
    localparam logic [STB_W-1:0] RD_LAST = STB_W'(RD_STROBE_CYC - 1);
    localparam logic [STB_W-1:0] WR_LAST = STB_W'(WR_STROBE_CYC - 1);
    localparam logic [BC_W-1:0]  BC_SAT  = BC_W'((BURST_MAX == 0) ? 1 : BURST_MAX);

    state_t             state_reg, state_next;
    logic [STB_W-1:0]   stb_reg, stb_next;
    logic [BC_W-1:0]    burst_reg, burst_next;
    dir_t               dir_reg, dir_next, dir_sel;
    logic               rxf_s, txe_s;
    logic               rx_ok, tx_ok, load_rx;
    logic               oe_reg, rd_reg, wr_reg, d_oe_reg, tx_ready_reg, rx_valid_reg;
    logic [DATA_W-1:0]  d_out_reg, rx_data_reg;

`ifdef FTDI_SYNC_EN
    ftdi_sync u_rxf_sync (.clk(clk), .n_rst(n_rst), .d(rxf), .q(rxf_s));
    ftdi_sync u_txe_sync (.clk(clk), .n_rst(n_rst), .d(txe), .q(txe_s));
`else
    assign rxf_s = rxf;
    assign txe_s = txe;
`endif

    assign rx_ok = !rxf_s && (!rx_valid_reg || rx_ready);
    assign tx_ok = !txe_s && tx_valid;

    always_comb begin
        state_next = state_reg;
        stb_next   = stb_reg;
        burst_next = burst_reg;
        dir_next   = dir_reg;
        dir_sel    = dir_reg;
        load_rx    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_ok && tx_ok) begin
                    // A zero count only exists straight after reset, where RX takes first pick.
                    if (burst_reg == '0 || (BURST_MAX != 0 && burst_reg == BC_SAT))
                        dir_sel = (dir_reg == DIR_RX) ? DIR_TX : DIR_RX;
                end else if (rx_ok) begin
                    dir_sel = DIR_RX;
                end else begin
                    dir_sel = DIR_TX;
                end
                if (rx_ok || tx_ok) begin
                    stb_next = '0;
                    dir_next = dir_sel;
                    // The count includes the transfer being started now.
                    if (dir_sel != dir_reg)
                        burst_next = BC_W'(1);
                    else if (burst_reg != BC_SAT)
                        burst_next = burst_reg + 1'b1;
                    state_next = (dir_sel == DIR_RX) ? RD_SETUP : WR_SETUP;
                end
            end
            RD_SETUP:   state_next = RD_STROBE;
            RD_STROBE: begin
                if (stb_reg == RD_LAST) begin
                    load_rx    = 1'b1;
                    state_next = RD_RECOVER;
                end else begin
                    stb_next = stb_reg + 1'b1;
                end
            end
            RD_RECOVER: state_next = IDLE;
            WR_SETUP:   state_next = WR_STROBE;
            WR_STROBE: begin
                if (stb_reg == WR_LAST)
                    state_next = WR_RECOVER;
                else
                    stb_next = stb_reg + 1'b1;
            end
            WR_RECOVER: state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Pin drivers are decoded from the next state so they are glitch-free flops aligned with state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= IDLE;
            stb_reg      <= '0;
            burst_reg    <= '0;
            dir_reg      <= DIR_TX;
            oe_reg       <= OFF;
            rd_reg       <= OFF;
            wr_reg       <= OFF;
            d_oe_reg     <= 1'b0;
            tx_ready_reg <= 1'b0;
            d_out_reg    <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            stb_reg      <= stb_next;
            burst_reg    <= burst_next;
            dir_reg      <= dir_next;
            oe_reg       <= (state_next == RD_SETUP || state_next == RD_STROBE) ? ON : OFF;
            rd_reg       <= (state_next == RD_STROBE) ? ON : OFF;
            wr_reg       <= (state_next == WR_STROBE) ? ON : OFF;
            d_oe_reg     <= (state_next == WR_SETUP || state_next == WR_STROBE ||
                             state_next == WR_RECOVER);
            tx_ready_reg <= (state_next == WR_SETUP);
            if (state_reg == IDLE && state_next == WR_SETUP)
                d_out_reg <= tx_data;
            if (load_rx) begin
                rx_data_reg  <= d_in;
                rx_valid_reg <= 1'b1;
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign oe       = oe_reg;
    assign rd       = rd_reg;
    assign wr       = wr_reg;
    assign d_oe     = d_oe_reg;
    assign d_out    = d_out_reg;
    assign tx_ready = tx_ready_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// Directed bench for ftdi_fifo_bridge: read, write, backpressure, async reset and burst fairness.
module tb_ftdi_fifo_bridge;

`ifdef FTDI_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rxf, txe;
    logic       oe, rd, wr, d_oe;
    logic [7:0] d_in, d_out, rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready, busy;

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    logic doe_prev = 1'b0;

    ftdi_fifo_bridge #(
        .DATA_W(8), .RD_STROBE_CYC(2), .WR_STROBE_CYC(2), .BURST_MAX(4)
    ) dut (
        .clk(clk), .n_rst(n_rst), .rxf(rxf), .txe(txe),
        .oe(oe), .rd(rd), .wr(wr),
        .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Bus-contention watch: rd/wr overlap, or oe low while d_oe is high now or was last cycle.
    always @(negedge clk) begin
        if (n_rst && ((!rd && !wr) || (!oe && (d_oe || doe_prev))))
            viol <= viol + 1;
        doe_prev <= d_oe;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        int   rd_low;
        int   nrec;
        logic found;
        logic prev_rd, prev_wr;
        logic seq     [12];
        logic exp_seq [12];

        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        n_rst = 1'b0; rxf = 1'b1; txe = 1'b1; d_in = 8'h00;
        rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        step(); step();
        check("reset_pins", {28'h0, oe, rd, wr, d_oe}, 32'hE);
        check("reset_flags", {29'h0, rx_valid, tx_ready, busy}, 32'h0);
        check("reset_data", {16'h0, d_out, rx_data}, 32'h0);
        n_rst = 1'b1;
        step(); step();

        // Single read of 0xA5.
        d_in = 8'hA5; rxf = 1'b0;
        lat = 99; found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (oe === 1'b0) begin found = 1'b1; lat = i + 1; end
        end
        check("rd_oe_latency", lat, 1 + SYNC_LAT);
        check("rd_setup", {29'h0, rd, busy, d_oe}, 32'h6);
        rxf = 1'b1;
        step(); check("rd_strobe1", {30'h0, rd, oe}, 32'h0);
        step(); check("rd_strobe2", {30'h0, rd, rx_valid}, 32'h0);
        step(); check("rd_recover", {29'h0, rd, oe, rx_valid}, 32'h7);
        check("rd_data", rx_data, 32'hA5);
        check("rd_busy_recover", busy, 1);
        step(); check("rd_idle", {30'h0, busy, rx_valid}, 32'h0);
        step(); step();

        // Single write of 0x3C.
        tx_data = 8'h3C; tx_valid = 1'b1; txe = 1'b0;
        lat = 99; found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (tx_ready === 1'b1) begin found = 1'b1; lat = i + 1; end
        end
        check("wr_ready_latency", lat, 1 + SYNC_LAT);
        check("wr_setup", {29'h0, d_oe, wr, oe}, 32'h7);
        check("wr_setup_data", d_out, 32'h3C);
        tx_valid = 1'b0; txe = 1'b1; tx_data = 8'hFF;
        step(); check("wr_strobe1", {29'h0, wr, d_oe, tx_ready}, 32'h2);
        check("wr_strobe1_data", d_out, 32'h3C);
        step(); check("wr_strobe2", {29'h0, wr, d_oe, tx_ready}, 32'h2);
        step(); check("wr_recover", {29'h0, wr, d_oe, tx_ready}, 32'h6);
        check("wr_recover_data", d_out, 32'h3C);
        step(); check("wr_idle", {30'h0, d_oe, busy}, 32'h0);
        step(); step();

        // Backpressure: one read only while rx_ready is low.
        rx_ready = 1'b0; d_in = 8'h11; rxf = 1'b0;
        rd_low = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (rd === 1'b0) rd_low++;
            if (i == 15) d_in = 8'h22;
        end
        check("bp_rd_low_cycles", rd_low, 2);
        check("bp_held_data", rx_data, 32'h11);
        check("bp_held_valid", rx_valid, 1);
        rx_ready = 1'b1;
        step(); check("bp_resume_setup", {30'h0, oe, rx_valid}, 32'h0);
        rxf = 1'b1;
        step(); check("bp_resume_rd", rd, 0);
        step();
        step(); check("bp_resume_valid", rx_valid, 1);
        check("bp_resume_data", rx_data, 32'h22);
        step(); step(); step();

        // Async reset during WR_STROBE with both directions pending.
        tx_data = 8'h5A; tx_valid = 1'b1; txe = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (wr === 1'b0) found = 1'b1;
        end
        check("rst_wr_seen", found, 1);
        rxf = 1'b0;
        #2 n_rst = 1'b0;
        #1 check("rst_async_pins", {28'h0, oe, rd, wr, d_oe}, 32'hE);
        check("rst_async_busy", busy, 0);
        @(posedge clk);
        #1 n_rst = 1'b1;

        // Burst fairness from reset: RX first, then 4/4 alternation.
        nrec = 0; prev_rd = rd; prev_wr = wr;
        for (int i = 0; i < 200 && nrec < 12; i++) begin
            step();
            if (prev_rd === 1'b1 && rd === 1'b0) begin seq[nrec] = 1'b0; nrec++; end
            else if (prev_wr === 1'b1 && wr === 1'b0) begin seq[nrec] = 1'b1; nrec++; end
            prev_rd = rd; prev_wr = wr;
        end
        check("burst_count", nrec, 12);
        for (int i = 0; i < 12; i++)
            if (i < nrec) check($sformatf("burst_dir_%0d", i), {31'h0, seq[i]}, {31'h0, exp_seq[i]});
        rxf = 1'b1; txe = 1'b1; tx_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();

        check("bus_contention", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
